// File: rtl/qubit_gate_unit.sv
// qubit_gate_unit: applies a selected 2x2 complex unitary (Q8.8) to the snapshotted (alpha, beta) pair.
// Latency: start sampled at E0 -> update_en/done high for one cycle after E5; one operation per 7 cycles.
// Backpressure: none; start is sampled only in IDLE, requests while busy are dropped (not queued).
module qubit_gate_unit #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              gate_sel,
    input  logic signed [WIDTH-1:0] alpha_re,
    input  logic signed [WIDTH-1:0] alpha_im,
    input  logic signed [WIDTH-1:0] beta_re,
    input  logic signed [WIDTH-1:0] beta_im,
    output logic signed [WIDTH-1:0] new_alpha_re,
    output logic signed [WIDTH-1:0] new_alpha_im,
    output logic signed [WIDTH-1:0] new_beta_re,
    output logic signed [WIDTH-1:0] new_beta_im,
    output logic                    update_en,
    output logic                    busy,
    output logic                    done,
    output logic                    sat
);

    // Product and accumulator widths: a full signed product, plus two guard bits
    // so the sum of two complex MAC terms can never wrap before saturation.
    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 2;

    // round(sqrt(x)) by bitwise search; used to derive 1/sqrt2 in fixed point.
    function automatic int isqrt_round(input longint x);
        longint n;
        longint cand;
        n = 0;
        for (int b = 31; b >= 0; b--) begin
            cand = n | (longint'(1) << b);
            if (cand * cand <= x) begin
                n = cand;
            end
        end
        // (n + 0.5)^2 = n^2 + n + 0.25, so round up when the remainder exceeds n.
        if (x - n * n > n) begin
            n = n + 1;
        end
        return int'(n);
    endfunction

    // round(2^FRAC / sqrt2) == round(sqrt(2^(2*FRAC-1))); 0x00B5 for FRAC=8.
    localparam int                     H_INT  = isqrt_round(longint'(1) << (2 * FRAC - 1));
    localparam logic signed [WIDTH-1:0] C_ZERO = '0;
    localparam logic signed [WIDTH-1:0] C_ONE  = WIDTH'(longint'(1) << FRAC);
    localparam logic signed [WIDTH-1:0] C_MONE = -C_ONE;
    localparam logic signed [WIDTH-1:0] C_H    = WIDTH'(H_INT);
    localparam logic signed [WIDTH-1:0] C_MH   = -C_H;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    localparam logic [2:0] G_I   = 3'd0;
    localparam logic [2:0] G_X   = 3'd1;
    localparam logic [2:0] G_Y   = 3'd2;
    localparam logic [2:0] G_Z   = 3'd3;
    localparam logic [2:0] G_H   = 3'd4;
    localparam logic [2:0] G_S   = 3'd5;
    localparam logic [2:0] G_T   = 3'd6;
    localparam logic [2:0] G_SDG = 3'd7;

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic cplx_t mk(input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

    // Matrix element for step k: 0=u00, 1=u01, 2=u10, 3=u11.
    function automatic cplx_t gate_coef(input logic [2:0] g, input logic [1:0] k);
        cplx_t c;
        c = mk(C_ZERO, C_ZERO);
        case (g)
            G_I:   if (k == 2'd0 || k == 2'd3) c = mk(C_ONE, C_ZERO);
            G_X:   if (k == 2'd1 || k == 2'd2) c = mk(C_ONE, C_ZERO);
            G_Y: begin
                if (k == 2'd1) c = mk(C_ZERO, C_MONE);
                if (k == 2'd2) c = mk(C_ZERO, C_ONE);
            end
            G_Z: begin
                if (k == 2'd0) c = mk(C_ONE, C_ZERO);
                if (k == 2'd3) c = mk(C_MONE, C_ZERO);
            end
            G_H:   c = (k == 2'd3) ? mk(C_MH, C_ZERO) : mk(C_H, C_ZERO);
            G_S: begin
                if (k == 2'd0) c = mk(C_ONE, C_ZERO);
                if (k == 2'd3) c = mk(C_ZERO, C_ONE);
            end
            G_T: begin
                if (k == 2'd0) c = mk(C_ONE, C_ZERO);
                if (k == 2'd3) c = mk(C_H, C_H);
            end
            G_SDG: begin
                if (k == 2'd0) c = mk(C_ONE, C_ZERO);
                if (k == 2'd3) c = mk(C_ZERO, C_MONE);
            end
            default: c = mk(C_ZERO, C_ZERO);
        endcase
        return c;
    endfunction

    // Drop the fraction (floor) and clamp to the word range; MSB of the result flags a clamp.
    function automatic logic [WIDTH:0] sat_word(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > SAT_MAX) begin
            return {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (sh < SAT_MIN) begin
            return {1'b1, SAT_MIN[WIDTH-1:0]};
        end
        return {1'b0, sh[WIDTH-1:0]};
    endfunction

    // Control and operand state
    state_t                  state_q;
    logic [1:0]              k_q;
    logic [2:0]              gate_q;
    logic signed [WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

    // Accumulators: A builds new alpha, B builds new beta.
    logic signed [AW-1:0]    acc_a_re_q, acc_a_im_q, acc_b_re_q, acc_b_im_q;

    // Registered outputs
    logic signed [WIDTH-1:0] new_a_re_q, new_a_im_q, new_b_re_q, new_b_im_q;
    logic                    update_en_q, busy_q, done_q, sat_q;

    // Datapath intermediates
    cplx_t                   coef_d;
    logic signed [WIDTH-1:0] coef_re_d, coef_im_d, opnd_re_d, opnd_im_d;
    logic signed [PW-1:0]    p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [AW-1:0]    prod_re_d, prod_im_d;
    logic [WIDTH:0]          fin_a_re_d, fin_a_im_d, fin_b_re_d, fin_b_im_d;

    // One complex multiply per cycle: coefficient for step k times alpha (even k) or beta (odd k).
    always_comb begin
        coef_d    = gate_coef(gate_q, k_q);
        coef_re_d = coef_d.re;
        coef_im_d = coef_d.im;
        opnd_re_d = k_q[0] ? b_re_q : a_re_q;
        opnd_im_d = k_q[0] ? b_im_q : a_im_q;
        p_rr_d    = PW'(coef_re_d) * PW'(opnd_re_d);
        p_ii_d    = PW'(coef_im_d) * PW'(opnd_im_d);
        p_ri_d    = PW'(coef_re_d) * PW'(opnd_im_d);
        p_ir_d    = PW'(coef_im_d) * PW'(opnd_re_d);
        prod_re_d = AW'(p_rr_d) - AW'(p_ii_d);
        prod_im_d = AW'(p_ri_d) + AW'(p_ir_d);
    end

    // Rescale and clamp the four accumulators for the WRITE step.
    always_comb begin
        fin_a_re_d = sat_word(acc_a_re_q);
        fin_a_im_d = sat_word(acc_a_im_q);
        fin_b_re_d = sat_word(acc_b_re_q);
        fin_b_im_d = sat_word(acc_b_im_q);
    end

    // Sequencer: IDLE snapshot -> four MAC steps -> WRITE result/strobe -> DONE guard cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= 2'd0;
            gate_q      <= 3'd0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            acc_a_re_q  <= '0;
            acc_a_im_q  <= '0;
            acc_b_re_q  <= '0;
            acc_b_im_q  <= '0;
            new_a_re_q  <= C_ONE;
            new_a_im_q  <= '0;
            new_b_re_q  <= '0;
            new_b_im_q  <= '0;
            update_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    update_en_q <= 1'b0;
                    done_q      <= 1'b0;
                    if (start) begin
                        gate_q     <= gate_sel;
                        a_re_q     <= alpha_re;
                        a_im_q     <= alpha_im;
                        b_re_q     <= beta_re;
                        b_im_q     <= beta_im;
                        acc_a_re_q <= '0;
                        acc_a_im_q <= '0;
                        acc_b_re_q <= '0;
                        acc_b_im_q <= '0;
                        k_q        <= 2'd0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (!k_q[1]) begin
                        acc_a_re_q <= acc_a_re_q + prod_re_d;
                        acc_a_im_q <= acc_a_im_q + prod_im_d;
                    end else begin
                        acc_b_re_q <= acc_b_re_q + prod_re_d;
                        acc_b_im_q <= acc_b_im_q + prod_im_d;
                    end
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    new_a_re_q  <= fin_a_re_d[WIDTH-1:0];
                    new_a_im_q  <= fin_a_im_d[WIDTH-1:0];
                    new_b_re_q  <= fin_b_re_d[WIDTH-1:0];
                    new_b_im_q  <= fin_b_im_d[WIDTH-1:0];
                    sat_q       <= fin_a_re_d[WIDTH] | fin_a_im_d[WIDTH] |
                                   fin_b_re_d[WIDTH] | fin_b_im_d[WIDTH];
                    update_en_q <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    // The state register loads on this edge; a new capture can only follow it.
                    update_en_q <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    update_en_q <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign new_alpha_re = new_a_re_q;
    assign new_alpha_im = new_a_im_q;
    assign new_beta_re  = new_b_re_q;
    assign new_beta_im  = new_b_im_q;
    assign update_en    = update_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_qubit_gate_unit.sv
// Bench for qubit_gate_unit: directed gate cases, random ops against a matrix-level model,
// held-start back-to-back behaviour and asynchronous reset in the middle of an operation.
module tb_qubit_gate_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  gate_sel;
    logic [15:0] alpha_re, alpha_im, beta_re, beta_im;
    logic [15:0] new_alpha_re, new_alpha_im, new_beta_re, new_beta_im;
    logic        update_en, busy, done, sat;

    qubit_gate_unit #(.WIDTH(16), .FRAC(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .gate_sel     (gate_sel),
        .alpha_re     (alpha_re),
        .alpha_im     (alpha_im),
        .beta_re      (beta_re),
        .beta_im      (beta_im),
        .new_alpha_re (new_alpha_re),
        .new_alpha_im (new_alpha_im),
        .new_beta_re  (new_beta_re),
        .new_beta_im  (new_beta_im),
        .update_en    (update_en),
        .busy         (busy),
        .done         (done),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Gate matrices as plain integers scaled by 256; element k: 0=u00 1=u01 2=u10 3=u11.
    longint m_re [8][4];
    longint m_im [8][4];

    logic [15:0] exp_val [4];
    logic        exp_sat;
    logic [15:0] obs_val [4];
    logic        obs_sat;
    logic        tr_ue [7];
    logic        tr_dn [7];
    logic        tr_bz [7];

    typedef struct packed {
        logic [2:0]       g;
        logic [3:0][15:0] amp;
        logic [3:0][15:0] res;
        logic             es;
    } dcase_t;

    task automatic init_model();
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) begin
                m_re[g][k] = 0;
                m_im[g][k] = 0;
            end
        end
        m_re[0][0] = 256;  m_re[0][3] = 256;                       // I
        m_re[1][1] = 256;  m_re[1][2] = 256;                       // X
        m_im[2][1] = -256; m_im[2][2] = 256;                       // Y
        m_re[3][0] = 256;  m_re[3][3] = -256;                      // Z
        m_re[4][0] = 181;  m_re[4][1] = 181; m_re[4][2] = 181; m_re[4][3] = -181; // H
        m_re[5][0] = 256;  m_im[5][3] = 256;                       // S
        m_re[6][0] = 256;  m_re[6][3] = 181; m_im[6][3] = 181;     // T
        m_re[7][0] = 256;  m_im[7][3] = -256;                      // Sdg
    endtask

    // new = U * old with exact integer sums, floor-divided by 256, then clamped to 16 bits.
    task automatic model_op(input int g, input longint ar, input longint ai, input longint br, input longint bi);
        longint xr [2];
        longint xi [2];
        longint acc_r, acc_i, v;
        xr[0] = ar; xi[0] = ai; xr[1] = br; xi[1] = bi;
        exp_sat = 1'b0;
        for (int r = 0; r < 2; r++) begin
            acc_r = 0;
            acc_i = 0;
            for (int c = 0; c < 2; c++) begin
                acc_r += m_re[g][2*r+c] * xr[c] - m_im[g][2*r+c] * xi[c];
                acc_i += m_re[g][2*r+c] * xi[c] + m_im[g][2*r+c] * xr[c];
            end
            for (int p = 0; p < 2; p++) begin
                v = ((p == 0) ? acc_r : acc_i) >>> 8;
                if (v > 32767) begin
                    v = 32767;
                    exp_sat = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    exp_sat = 1'b1;
                end
                exp_val[2*r+p] = 16'(v);
            end
        end
    endtask

    // Drive one request and record outputs over edges E0..E6 (sampled 1 time unit after each edge).
    task automatic do_op(input logic [2:0] g, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi, input bit hold, input bit perturb);
        @(negedge clk);
        gate_sel = g;
        alpha_re = ar; alpha_im = ai; beta_re = br; beta_im = bi;
        start    = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(posedge clk);
            #1;
            tr_ue[e] = update_en;
            tr_dn[e] = done;
            tr_bz[e] = busy;
            if (e == 5) begin
                obs_val[0] = new_alpha_re;
                obs_val[1] = new_alpha_im;
                obs_val[2] = new_beta_re;
                obs_val[3] = new_beta_im;
                obs_sat    = sat;
            end
            if (e == 0) begin
                if (!hold) start = 1'b0;
                if (perturb) begin
                    alpha_re = 16'($urandom);
                    alpha_im = 16'($urandom);
                    beta_re  = 16'($urandom);
                    beta_im  = 16'($urandom);
                    gate_sel = 3'($urandom);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        gate_sel = 3'd0;
        alpha_re = '0; alpha_im = '0; beta_re = '0; beta_im = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (new_alpha_re !== 16'h0100 || new_alpha_im !== 16'h0000 ||
            new_beta_re !== 16'h0000 || new_beta_im !== 16'h0000) begin
            fails++;
            $display("FAIL reset_amps got=%h %h %h %h exp=0100 0000 0000 0000",
                     new_alpha_re, new_alpha_im, new_beta_re, new_beta_im);
        end
        tests_run++;
        if ({update_en, busy, done, sat} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got ue/busy/done/sat=%b exp=0000", {update_en, busy, done, sat});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({update_en, busy, done} !== 3'b000 || new_alpha_re !== 16'h0100) begin
            fails++;
            $display("FAIL post_reset_idle got ue/busy/done=%b alpha_re=%h exp=000 0100",
                     {update_en, busy, done}, new_alpha_re);
        end
    endtask

    task automatic test_directed();
        dcase_t dc [9];
        dcase_t d;
        dc[0] = {3'd4, {16'h0000, 16'h0000, 16'h0000, 16'h0100}, {16'h0000, 16'h00B5, 16'h0000, 16'h00B5}, 1'b0}; // H|0>
        dc[1] = {3'd4, {16'h0000, 16'h00B5, 16'h0000, 16'h00B5}, {16'h0000, 16'h0000, 16'h0000, 16'h00FF}, 1'b0}; // H|+>
        dc[2] = {3'd2, {16'h0000, 16'h0000, 16'h0000, 16'h0100}, {16'h0100, 16'h0000, 16'h0000, 16'h0000}, 1'b0}; // Y|0>
        dc[3] = {3'd6, {16'h0000, 16'h0100, 16'h0000, 16'h0000}, {16'h00B5, 16'h00B5, 16'h0000, 16'h0000}, 1'b0}; // T|1>
        dc[4] = {3'd4, {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF}, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b1}; // H max
        dc[5] = {3'd3, {16'h0000, 16'h8000, 16'h0000, 16'h0000}, {16'h0000, 16'h7FFF, 16'h0000, 16'h0000}, 1'b1}; // Z min
        dc[6] = {3'd1, {16'hFFC0, 16'h0040, 16'h0020, 16'h0100}, {16'h0020, 16'h0100, 16'hFFC0, 16'h0040}, 1'b0}; // X swap
        dc[7] = {3'd5, {16'h0008, 16'h0030, 16'h0000, 16'h0010}, {16'h0030, 16'hFFF8, 16'h0000, 16'h0010}, 1'b0}; // S
        dc[8] = {3'd7, {16'h0008, 16'h0030, 16'h0000, 16'h0010}, {16'hFFD0, 16'h0008, 16'h0000, 16'h0010}, 1'b0}; // Sdg
        for (int n = 0; n < 9; n++) begin
            d = dc[n];
            do_op(d.g, d.amp[0], d.amp[1], d.amp[2], d.amp[3], 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (obs_val[j] !== d.res[j]) begin
                    fails++;
                    $display("FAIL directed[%0d] word%0d got=%h exp=%h", n, j, obs_val[j], d.res[j]);
                end
            end
            tests_run++;
            if (obs_sat !== d.es) begin
                fails++;
                $display("FAIL directed[%0d] sat got=%b exp=%b", n, obs_sat, d.es);
            end
            for (int e = 0; e < 7; e++) begin
                tests_run++;
                if (tr_ue[e] !== (e == 5) || tr_dn[e] !== (e == 5) || tr_bz[e] !== (e <= 5)) begin
                    fails++;
                    $display("FAIL directed[%0d] timing E%0d got ue/done/busy=%b%b%b exp=%b%b%b",
                             n, e, tr_ue[e], tr_dn[e], tr_bz[e], e == 5, e == 5, e <= 5);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  g;
        logic [15:0] v [4];
        for (int n = 0; n < 40; n++) begin
            g = 3'($urandom_range(0, 7));
            for (int j = 0; j < 4; j++) begin
                v[j] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            end
            do_op(g, v[0], v[1], v[2], v[3], 1'b0, 1'b0);
            model_op(int'(g), longint'($signed(v[0])), longint'($signed(v[1])),
                     longint'($signed(v[2])), longint'($signed(v[3])));
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (obs_val[j] !== exp_val[j]) begin
                    fails++;
                    $display("FAIL random[%0d] gate=%0d word%0d got=%h exp=%h", n, g, j, obs_val[j], exp_val[j]);
                end
            end
            tests_run++;
            if (obs_sat !== exp_sat || tr_ue[5] !== 1'b1 || tr_ue[6] !== 1'b0) begin
                fails++;
                $display("FAIL random[%0d] gate=%0d sat/ue5/ue6 got=%b%b%b exp=%b10",
                         n, g, obs_sat, tr_ue[5], tr_ue[6], exp_sat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v [4];
        bit          bad;
        for (int j = 0; j < 4; j++) v[j] = 16'($urandom_range(0, 2047) - 1024);
        // First op: start held high, inputs scrambled right after E0.
        do_op(3'd4, v[0], v[1], v[2], v[3], 1'b1, 1'b1);
        model_op(4, longint'($signed(v[0])), longint'($signed(v[1])),
                 longint'($signed(v[2])), longint'($signed(v[3])));
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (obs_val[j] !== exp_val[j]) begin
                fails++;
                $display("FAIL snapshot word%0d got=%h exp=%h", j, obs_val[j], exp_val[j]);
            end
        end
        bad = 1'b0;
        for (int e = 0; e < 7; e++) begin
            if (tr_ue[e] !== (e == 5) || tr_bz[e] !== (e <= 5)) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL held_start_timing ue=%b%b%b%b%b%b%b busy=%b%b%b%b%b%b%b exp ue=0000010 busy=1111110",
                     tr_ue[0], tr_ue[1], tr_ue[2], tr_ue[3], tr_ue[4], tr_ue[5], tr_ue[6],
                     tr_bz[0], tr_bz[1], tr_bz[2], tr_bz[3], tr_bz[4], tr_bz[5], tr_bz[6]);
        end
        // Second op: start still high, so capture must land on E7.
        for (int j = 0; j < 4; j++) v[j] = 16'($urandom);
        do_op(3'd6, v[0], v[1], v[2], v[3], 1'b1, 1'b0);
        start = 1'b0;
        model_op(6, longint'($signed(v[0])), longint'($signed(v[1])),
                 longint'($signed(v[2])), longint'($signed(v[3])));
        tests_run++;
        if (tr_bz[0] !== 1'b1 || tr_ue[5] !== 1'b1 || tr_ue[4] !== 1'b0 || tr_ue[6] !== 1'b0) begin
            fails++;
            $display("FAIL second_capture_E7 busy@E7=%b ue@E11/12/13=%b%b%b exp=1 010",
                     tr_bz[0], tr_ue[4], tr_ue[5], tr_ue[6]);
        end
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (obs_val[j] !== exp_val[j]) begin
                fails++;
                $display("FAIL second_op word%0d got=%h exp=%h", j, obs_val[j], exp_val[j]);
            end
        end
        // Results and sat hold while idle.
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || update_en !== 1'b0 || sat !== exp_sat ||
                new_alpha_re !== exp_val[0] || new_alpha_im !== exp_val[1] ||
                new_beta_re !== exp_val[2] || new_beta_im !== exp_val[3]) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL idle_hold got busy=%b ue=%b sat=%b alpha_re=%h exp busy=0 ue=0 sat=%b alpha_re=%h",
                     busy, update_en, sat, new_alpha_re, exp_sat, exp_val[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_op(3'd4, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        gate_sel = 3'd1;
        alpha_re = 16'h0123; alpha_im = 16'h0045; beta_re = 16'hFF00; beta_im = 16'h0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_at_E2 got=%b exp=1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (new_alpha_re !== 16'h0100 || new_alpha_im !== 16'h0000 ||
            new_beta_re !== 16'h0000 || new_beta_im !== 16'h0000 ||
            {update_en, busy, done, sat} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset got=%h %h %h %h flags=%b exp=0100 0000 0000 0000 flags=0000",
                     new_alpha_re, new_alpha_im, new_beta_re, new_beta_im, {update_en, busy, done, sat});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (update_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            fails++;
            $display("FAIL no_strobe_after_reset got ue/done/busy=%b exp=000", {update_en, done, busy});
        end
        do_op(3'd3, 16'h0123, 16'h0045, 16'hFF00, 16'h0010, 1'b0, 1'b0);
        model_op(3, 64'sh0123, 64'sh0045, -64'sh0100, 64'sh0010);
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (obs_val[j] !== exp_val[j] || tr_ue[5] !== 1'b1) begin
                fails++;
                $display("FAIL after_reset_op word%0d got=%h ue=%b exp=%h ue=1", j, obs_val[j], tr_ue[5], exp_val[j]);
            end
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
